demux_dist: RTL and testbench
=============================

DEMUX_DIST -- requirements
Module: demux_dist

Interface
REQ-001 Parameter WIDTH, default 7: data bits per word; legal range 1..64.
REQ-002 Parameter NCH, default 2: number of output channels; legal range 2..16.
REQ-003 Derived parameter SELW = max(1, ceil(log2(NCH))): select-field width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  WIDTH  word to distribute.
REQ-007 in_valid  input  1  in_data is offered this cycle.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 sel  input  SELW  target channel index in select mode.
REQ-010 mode  input  1  0 = select mode, 1 = round-robin mode.
REQ-011 out_data  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 out_valid  output  NCH  bit k set = channel k holds a word.
REQ-013 out_ready  input  NCH  bit k set = consumer k takes its word this cycle.
REQ-014 sel_err  output  1  registered one-cycle pulse on an out-of-range select.

Function
REQ-015 Each channel SHALL have one holding register (data plus full flag); out_valid[k] SHALL equal full flag k.
REQ-016 While out_valid[k]=0, the out_data slice for channel k SHALL be all zeros.
REQ-017 Target channel T SHALL be sel in select mode and rr_ptr in round-robin mode.
REQ-018 in_ready SHALL be 1 iff T < NCH and (out_valid[T]=0 or out_ready[T]=1); it is combinational from current state, sel, mode and out_ready.
REQ-019 Acceptance occurs when in_valid and in_ready are both 1; in_data SHALL appear on channel T with out_valid[T]=1 on the next cycle (latency 1).
REQ-020 A drain occurs on channel k when out_valid[k] and out_ready[k] are both 1; without a simultaneous accept to k, out_valid[k] SHALL clear next cycle.
REQ-021 Simultaneous drain and accept on the same channel SHALL load the new word with out_valid held at 1, with no bubble and no word lost.
REQ-022 Accepts to one channel SHALL NOT stall drains on, or alter contents of, any other channel.
REQ-023 rr_ptr (SELW bits) SHALL advance by one on each accept in round-robin mode and wrap from NCH-1 to 0; it SHALL hold otherwise.
REQ-024 In round-robin mode, if channel rr_ptr is full and not draining, in_ready SHALL be 0; the pointer SHALL NOT skip to a free channel.
REQ-025 In select mode with sel >= NCH (only possible when NCH is not a power of 2), in_ready SHALL be 0; sel_err SHALL pulse for one cycle on the cycle after in_valid=1 was sampled with that select.
REQ-026 A mode change SHALL take effect on the same cycle; rr_ptr SHALL keep its value across mode changes.
REQ-027 Out-of-range handling SHALL apply only to sel; rr_ptr SHALL never exceed NCH-1.

Reset
REQ-028 Asserting rst_n low SHALL immediately clear all full flags, the data registers, rr_ptr and sel_err, at any time including mid-transfer.
REQ-029 Under reset, out_valid=0, out_data=0, sel_err=0 and in_ready=0.
REQ-030 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge at which rst_n is sampled high.

Configuration
REQ-031 Macro DEMUX_DIST_RR_EN, when defined, SHALL compile in round-robin mode and the rr_ptr logic.
REQ-032 With DEMUX_DIST_RR_EN undefined, the mode port SHALL remain present but be ignored, operation SHALL be select mode only, and no rr_ptr register SHALL be synthesised.

Verification
REQ-033 WIDTH=7, NCH=2, select mode, sel=1, in_data=7'h55, in_valid=1 for 1 cycle -> next cycle out_valid=2'b10, channel 1 slice=7'h55, channel 0 slice=0.
REQ-034 NCH=2, channel 0 full, out_ready[0]=0, sel=0, in_valid=1 -> in_ready=0 and the word is held; raise out_ready[0] -> accept and drain in the same cycle, out_valid[0] stays 1 and data updates.
REQ-035 DEMUX_DIST_RR_EN defined, NCH=3, mode=1, all out_ready=1, 4 words 1,2,3,4 -> delivered to channels 0,1,2,0, and rr_ptr=1 afterwards.
REQ-036 NCH=3, select mode, sel=3, in_valid=1 -> in_ready=0, then a sel_err pulse one cycle later, and no out_valid change.
REQ-037 rst_n low while channels are full -> out_valid=0 and out_data=0 asynchronously; after release rr_ptr=0 and the first word goes to channel 0.

Source files
------------

// File: rtl/demux_dist.sv
// demux_dist: distributes one input word per cycle to NCH registered output channels.
// Round-robin mode and the rr_ptr register are compiled in only with DEMUX_DIST_RR_EN.
module demux_dist #(
  parameter int WIDTH = 7,
  parameter int NCH = 2,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic                 sel_err
);
  logic [NCH-1:0][WIDTH-1:0] data_q, data_d, data_vis;
  logic [NCH-1:0] full_q, full_d, hit;
  logic [SELW-1:0] tgt;
  logic sel_mode, acc, sel_err_q, sel_err_d;
`ifdef DEMUX_DIST_RR_EN
  logic [SELW-1:0] rr_q, rr_d;
  assign sel_mode = ~mode;
  assign tgt = mode ? rr_q : sel;
  assign rr_d = (mode && acc) ? ((32'(rr_q) == NCH - 1) ? '0 : rr_q + SELW'(1)) : rr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_q <= '0;
    else rr_q <= rr_d;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign sel_mode = 1'b1;
  assign tgt = sel;
`endif
  // An out-of-range target matches no channel, so in_ready falls to 0 naturally.
  always_comb begin
    hit = '0;
    full_d = full_q;
    data_d = data_q;
    data_vis = '0;
    for (int k = 0; k < NCH; k++) hit[k] = 32'(tgt) == k;
    in_ready = rst_n && |(hit & (~full_q | out_ready));
    acc = in_valid && in_ready;
    for (int k = 0; k < NCH; k++) begin
      full_d[k] = (acc && hit[k]) || (full_q[k] && !out_ready[k]);
      data_d[k] = (acc && hit[k]) ? in_data : data_q[k];
      data_vis[k] = full_q[k] ? data_q[k] : '0;
    end
    sel_err_d = in_valid && sel_mode && (32'(sel) >= NCH);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full_q <= '0;
      data_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sel_err_q <= sel_err_d;
    end
  assign out_data = data_vis;
  assign out_valid = full_q;
  assign sel_err = sel_err_q;
endmodule

// File: tb/tb_demux_dist.sv
// tb_demux_dist: directed checks of demux_dist with NCH=2 and NCH=3 instances.
module tb_demux_dist;
  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] d2, d3;
  logic v2, v3, r2, r3, m2, m3, e2, e3;
  logic [0:0] s2;
  logic [1:0] s3;
  logic [13:0] od2;
  logic [20:0] od3;
  logic [1:0] ov2, or2;
  logic [2:0] ov3, or3;
  int checks = 0;
  int errors = 0;
`ifdef DEMUX_DIST_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clk = ~clk;

  demux_dist #(.WIDTH(7), .NCH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
    .mode(m2), .out_data(od2), .out_valid(ov2), .out_ready(or2), .sel_err(e2));
  demux_dist #(.WIDTH(7), .NCH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3), .sel(s3),
    .mode(m3), .out_data(od3), .out_valid(ov3), .out_ready(or3), .sel_err(e3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; v2 = 1'b1; s2 = 1'b0; d2 = 7'h11; m2 = 1'b0; or2 = 2'b00;
    v3 = 1'b0; s3 = 2'd0; d3 = 7'h00; m3 = 1'b0; or3 = 3'b000;
    #3;
    checks++; if (ov2 !== 2'b00) begin errors++; $display("FAIL rst_ov2: got %b expected 00", ov2); end
    checks++; if (od2 !== 14'h0) begin errors++; $display("FAIL rst_od2: got %h expected 0", od2); end
    checks++; if (e2 !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", e2); end
    checks++; if (r2 !== 1'b0 || r3 !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b%b expected 00", r2, r3); end
    tick;
    rst_n = 1'b1;
    #1;
    checks++; if (r2 !== 1'b1) begin errors++; $display("FAIL first_ready: got %b expected 1", r2); end
    tick;
    v2 = 1'b0;
    checks++; if (ov2 !== 2'b01 || od2[6:0] !== 7'h11) begin errors++; $display("FAIL first_accept: got %b/%h expected 01/11", ov2, od2[6:0]); end
    tick;
    checks++; if (ov2 !== 2'b01) begin errors++; $display("FAIL hold: got %b expected 01", ov2); end
    or2 = 2'b11;
    tick;
    or2 = 2'b00;
    checks++; if (ov2 !== 2'b00 || od2 !== 14'h0) begin errors++; $display("FAIL drain: got %b/%h expected 00/0", ov2, od2); end
  endtask

  task automatic test_select;
    s2 = 1'b1; d2 = 7'h55; v2 = 1'b1;
    tick;
    v2 = 1'b0;
    checks++; if (ov2 !== 2'b10) begin errors++; $display("FAIL sel_ov: got %b expected 10", ov2); end
    checks++; if (od2[13:7] !== 7'h55 || od2[6:0] !== 7'h00) begin errors++; $display("FAIL sel_data: got %h expected 55/00", od2); end
    or2 = 2'b10;
    tick;
    or2 = 2'b00;
    checks++; if (ov2 !== 2'b00 || od2 !== 14'h0) begin errors++; $display("FAIL sel_drain: got %b/%h expected 00/0", ov2, od2); end
  endtask

  task automatic test_back_to_back;
    s2 = 1'b0; d2 = 7'h0A; v2 = 1'b1;
    tick;
    d2 = 7'h0B;
    #1;
    checks++; if (r2 !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", r2); end
    tick;
    checks++; if (ov2 !== 2'b01 || od2[6:0] !== 7'h0A) begin errors++; $display("FAIL bp_hold: got %b/%h expected 01/0a", ov2, od2[6:0]); end
    or2 = 2'b01;
    #1;
    checks++; if (r2 !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", r2); end
    tick;
    v2 = 1'b0;
    checks++; if (ov2 !== 2'b01 || od2[6:0] !== 7'h0B) begin errors++; $display("FAIL b2b: got %b/%h expected 01/0b", ov2, od2[6:0]); end
    tick;
    or2 = 2'b00;
    checks++; if (ov2 !== 2'b00) begin errors++; $display("FAIL b2b_drain: got %b expected 00", ov2); end
  endtask

  task automatic test_independence;
    s2 = 1'b0; d2 = 7'h21; v2 = 1'b1;
    tick;
    s2 = 1'b1; d2 = 7'h31;
    tick;
    v2 = 1'b0;
    checks++; if (ov2 !== 2'b11 || od2 !== {7'h31, 7'h21}) begin errors++; $display("FAIL indep_fill: got %b/%h expected 11/%h", ov2, od2, {7'h31, 7'h21}); end
    or2 = 2'b10;
    tick;
    checks++; if (ov2 !== 2'b01 || od2 !== {7'h00, 7'h21}) begin errors++; $display("FAIL indep_drain: got %b/%h expected 01/%h", ov2, od2, {7'h00, 7'h21}); end
    or2 = 2'b01;
    tick;
    or2 = 2'b00;
  endtask

  task automatic test_sel_err;
    s3 = 2'd3; v3 = 1'b1; m3 = 1'b0;
    #1;
    checks++; if (r3 !== 1'b0) begin errors++; $display("FAIL oor_ready: got %b expected 0", r3); end
    tick;
    v3 = 1'b0;
    checks++; if (e3 !== 1'b1 || ov3 !== 3'b000) begin errors++; $display("FAIL oor_err: got %b/%b expected 1/000", e3, ov3); end
    s3 = 2'd2; d3 = 7'h4C; v3 = 1'b1;
    tick;
    v3 = 1'b0;
    checks++; if (e3 !== 1'b0) begin errors++; $display("FAIL err_pulse: got %b expected 0", e3); end
    checks++; if (ov3 !== 3'b100 || od3[20:14] !== 7'h4C) begin errors++; $display("FAIL sel2: got %b/%h expected 100/4c", ov3, od3[20:14]); end
    or3 = 3'b100;
    tick;
    or3 = 3'b000;
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_ov [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    int exp_ch [5] = '{0, 1, 2, 0, 1};
    m3 = 1'b1; or3 = 3'b111; s3 = 2'd2;
    for (int i = 0; i < 5; i++) begin
      d3 = 7'(i + 1); v3 = 1'b1;
      tick;
      checks++;
      if (ov3 !== exp_ov[i] || od3[exp_ch[i]*7 +: 7] !== 7'(i + 1)) begin
        errors++; $display("FAIL rr_word%0d: got %b/%h expected %b/%h", i, ov3, od3, exp_ov[i], 7'(i + 1));
      end
    end
    v3 = 1'b0;
    tick;
    or3 = 3'b000;
    m3 = 1'b0;
  endtask

  task automatic test_async_reset;
    s2 = 1'b0; d2 = 7'h66; v2 = 1'b1;
    s3 = 2'd1; d3 = 7'h77; v3 = 1'b1;
    tick;
    s2 = 1'b1; d2 = 7'h67; v3 = 1'b0;
    tick;
    v2 = 1'b0;
    checks++; if (ov2 !== 2'b11 || ov3 !== 3'b010) begin errors++; $display("FAIL pre_rst: got %b/%b expected 11/010", ov2, ov3); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (ov2 !== 2'b00 || od2 !== 14'h0 || ov3 !== 3'b000 || od3 !== 21'h0) begin errors++; $display("FAIL async_rst: got %b/%h %b/%h expected all 0", ov2, od2, ov3, od3); end
    tick;
    rst_n = 1'b1; m3 = 1'b1; s3 = 2'd2; d3 = 7'h12; v3 = 1'b1;
    tick;
    v3 = 1'b0;
    checks++; if (ov3 !== (RR ? 3'b001 : 3'b100)) begin errors++; $display("FAIL post_rst: got %b expected %b", ov3, RR ? 3'b001 : 3'b100); end
    m3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_select;
    test_back_to_back;
    test_independence;
    test_sel_err;
`ifdef DEMUX_DIST_RR_EN
    test_round_robin;
`endif
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
